// File: rtl/accumulator_cpu_if.sv
// Host/peripheral-facing bus of the accumulator processor: program load, start,
// input handshake and status outputs grouped into one interface.
interface accumulator_cpu_if #(
    parameter int DW = 8,
    parameter int AW = 5
);
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          Aeq0;
    logic          Apos;
    logic [AW-1:0] pc_out;
    logic          halted;

    modport master (
        output start, mem_we, mem_addr, mem_wdata, data_in, in_valid,
        input  in_ready, data_out, Aeq0, Apos, pc_out, halted
    );

    modport slave (
        input  start, mem_we, mem_addr, mem_wdata, data_in, in_valid,
        output in_ready, data_out, Aeq0, Apos, pc_out, halted
    );
endinterface

// File: rtl/accumulator_cpu.sv
// Accumulator processor: PC/IR/A datapath, internal RAM and a
// fetch/decode/execute controller with an input handshake and host load port.
module accumulator_cpu #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    accumulator_cpu_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        INPUT,
        HALT
    } state_e;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] mem_q [0:(2**AW)-1];

    logic [2:0]    opcode;
    logic [AW-1:0] irAddr;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          memWe;
    logic [AW-1:0] memWAddr;
    logic [DW-1:0] memWData;
    logic          aIsZero;
    logic          aIsPos;
    logic          irUnused;

    assign opcode   = ir_q[DW-1:DW-3];
    assign irAddr   = ir_q[AW-1:0];
    assign irUnused = ^ir_q;
    assign rdAddr   = (state_q == FETCH) ? pc_q : irAddr;
    assign rdData   = mem_q[rdAddr];
    assign aIsZero  = (a_q == '0);
    assign aIsPos   = !a_q[DW-1] && !aIsZero;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        memWe    = 1'b0;
        memWAddr = irAddr;
        memWData = a_q;

        case (state_q)
            IDLE, HALT: begin
                // Host writes and start are only honoured while the core is parked.
                if (bus.mem_we) begin
                    memWe    = 1'b1;
                    memWAddr = bus.mem_addr;
                    memWData = bus.mem_wdata;
                end
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = rdData;
                pc_d    = pc_q + AW'(1);
                state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_IN:   state_d = INPUT;
                    OP_HALT: state_d = HALT;
                    default: state_d = EXECUTE;
                endcase
            end
            EXECUTE: begin
                case (opcode)
                    OP_LOAD:  a_d = rdData;
                    OP_STORE: memWe = 1'b1;
                    OP_ADD:   a_d = a_q + rdData;
                    OP_SUB:   a_d = a_q - rdData;
                    OP_JZ:    if (aIsZero) pc_d = irAddr;
                    OP_JPOS:  if (aIsPos) pc_d = irAddr;
                    default:  ;
                endcase
                state_d = FETCH;
            end
            INPUT: begin
                if (bus.in_valid) begin
                    a_d     = bus.data_in;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
        end
    end

    // RAM keeps its contents across reset; reset only blocks the write.
    always_ff @(posedge clk_i) begin
        if (rst_ni && memWe) begin
            mem_q[memWAddr] <= memWData;
        end
    end

    assign bus.in_ready = (state_q == INPUT);
    assign bus.halted   = (state_q == HALT);
    assign bus.data_out = a_q;
    assign bus.Aeq0     = aIsZero;
    assign bus.Apos     = aIsPos;
    assign bus.pc_out   = pc_q;
endmodule

// File: tb/tb_accumulator_cpu.sv
// Directed testbench for accumulator_cpu: an 8/5 instance for program-level
// scenarios and a 6/3 instance for PC wrap-around.
module tb_accumulator_cpu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   jumpBack = 0;
    int   cycles;
    int   readyCount;

    always #5 clk = ~clk;

    accumulator_cpu_if #(.DW(8), .AW(5)) ifA ();
    accumulator_cpu_if #(.DW(6), .AW(3)) ifB ();

    accumulator_cpu #(.DW(8), .AW(5)) dutA (.clk_i(clk), .rst_ni(rst_n), .bus(ifA.slave));
    accumulator_cpu #(.DW(6), .AW(3)) dutB (.clk_i(clk), .rst_ni(rst_n), .bus(ifB.slave));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic writeA(input logic [4:0] addr, input logic [7:0] data);
        ifA.mem_we    = 1'b1;
        ifA.mem_addr  = addr;
        ifA.mem_wdata = data;
        step(1);
        ifA.mem_we    = 1'b0;
    endtask

    task automatic writeB(input logic [2:0] addr, input logic [5:0] data);
        ifB.mem_we    = 1'b1;
        ifB.mem_addr  = addr;
        ifB.mem_wdata = data;
        step(1);
        ifB.mem_we    = 1'b0;
    endtask

    task automatic startA();
        ifA.start = 1'b1;
        step(1);
        ifA.start = 1'b0;
    endtask

    // Counts edges after the start edge until halted; tracks JPOS back-jumps 4->1.
    task automatic waitHaltA(input int maxCycles, output int count);
        logic [4:0] prevPc;
        count = 0;
        while (!ifA.halted && count < maxCycles) begin
            prevPc = ifA.pc_out;
            step(1);
            count++;
            if (prevPc == 5'd4 && ifA.pc_out == 5'd1) jumpBack++;
        end
        if (!ifA.halted) checkOutput("haltTimeout", 32'(ifA.halted), 32'd1);
    endtask

    initial begin
        ifA.start = 0; ifA.mem_we = 0; ifA.mem_addr = '0; ifA.mem_wdata = '0;
        ifA.data_in = '0; ifA.in_valid = 0;
        ifB.start = 0; ifB.mem_we = 0; ifB.mem_addr = '0; ifB.mem_wdata = '0;
        ifB.data_in = '0; ifB.in_valid = 0;

        step(2);
        rst_n = 1'b1;
        checkOutput("rstDataOut", 32'(ifA.data_out), 32'h0);
        checkOutput("rstAeq0",    32'(ifA.Aeq0),     32'd1);
        checkOutput("rstApos",    32'(ifA.Apos),     32'd0);
        checkOutput("rstPc",      32'(ifA.pc_out),   32'd0);
        checkOutput("rstHalted",  32'(ifA.halted),   32'd0);
        checkOutput("rstInReady", 32'(ifA.in_ready), 32'd0);

        // Add program
        writeA(5'd0, 8'h0A); writeA(5'd1, 8'h4B); writeA(5'd2, 8'h2C);
        writeA(5'd3, 8'hE0); writeA(5'd10, 8'd5); writeA(5'd11, 8'd7);
        startA();
        waitHaltA(100, cycles);
        checkOutput("addCycles",  32'(cycles),          32'd11);
        checkOutput("addPc",      32'(ifA.pc_out),      32'd4);
        checkOutput("addM12",     32'(dutA.mem_q[12]),  32'd12);
        checkOutput("addDataOut", 32'(ifA.data_out),    32'd12);
        checkOutput("addAeq0",    32'(ifA.Aeq0),        32'd0);
        checkOutput("addApos",    32'(ifA.Apos),        32'd1);

        // Host write during EXECUTE of ADD, then reset
        startA();
        step(5);
        checkOutput("midPc", 32'(ifA.pc_out), 32'd2);
        ifA.mem_we = 1'b1; ifA.mem_addr = 5'd12; ifA.mem_wdata = 8'h99;
        step(1);
        ifA.mem_we = 1'b0;
        checkOutput("midAdd", 32'(ifA.data_out), 32'd12);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        checkOutput("ignoredWrM12", 32'(dutA.mem_q[12]), 32'd12);
        checkOutput("rst2DataOut",  32'(ifA.data_out),   32'h0);
        checkOutput("rst2Aeq0",     32'(ifA.Aeq0),       32'd1);
        checkOutput("rst2Pc",       32'(ifA.pc_out),     32'd0);
        checkOutput("rst2Halted",   32'(ifA.halted),     32'd0);
        step(3);
        checkOutput("idleHoldPc", 32'(ifA.pc_out), 32'd0);
        startA();
        waitHaltA(100, cycles);
        checkOutput("rerunCycles",  32'(cycles),         32'd11);
        checkOutput("rerunDataOut", 32'(ifA.data_out),   32'd12);
        checkOutput("rerunM12",     32'(dutA.mem_q[12]), 32'd12);

        // SUB wrap: 3 - 5
        writeA(5'd0, 8'h0D); writeA(5'd1, 8'h6A); writeA(5'd2, 8'hE0); writeA(5'd13, 8'd3);
        startA();
        waitHaltA(100, cycles);
        checkOutput("subDataOut", 32'(ifA.data_out), 32'hFE);
        checkOutput("subApos",    32'(ifA.Apos),     32'd0);
        checkOutput("subAeq0",    32'(ifA.Aeq0),     32'd0);

        // Countdown loop
        writeA(5'd20, 8'd3); writeA(5'd21, 8'd1);
        writeA(5'd0, 8'h14); writeA(5'd1, 8'h75); writeA(5'd2, 8'hA6); writeA(5'd3, 8'hC1);
        writeA(5'd4, 8'hE0); writeA(5'd5, 8'hE0); writeA(5'd6, 8'hE0);
        jumpBack = 0;
        startA();
        waitHaltA(200, cycles);
        checkOutput("loopCycles",   32'(cycles),       32'd29);
        checkOutput("loopExitPc",   32'(ifA.pc_out),   32'd7);
        checkOutput("loopDataOut",  32'(ifA.data_out), 32'h0);
        checkOutput("loopAeq0",     32'(ifA.Aeq0),     32'd1);
        checkOutput("loopJposTaken", 32'(jumpBack),    32'd2);

        // IN handshake: IN; STORE 12; HALT
        writeA(5'd0, 8'h80); writeA(5'd1, 8'h2C); writeA(5'd2, 8'hE0);
        startA();
        step(1);
        checkOutput("inDecodeReady", 32'(ifA.in_ready), 32'd0);
        step(1);
        readyCount = 0;
        ifA.data_in = 8'h55;
        for (int i = 0; i < 5; i++) begin
            if (ifA.in_ready) readyCount++;
            if (i == 4) begin
                ifA.data_in  = 8'h33;
                ifA.in_valid = 1'b1;
            end
            step(1);
            if (i == 3) checkOutput("inWaitA", 32'(ifA.data_out), 32'h0);
        end
        ifA.in_valid = 1'b0;
        checkOutput("inReadyCycles", 32'(readyCount),   32'd5);
        checkOutput("inAccepted",    32'(ifA.data_out), 32'h33);
        checkOutput("inReadyDrop",   32'(ifA.in_ready), 32'd0);
        step(1);
        checkOutput("inNextFetchPc", 32'(ifA.pc_out), 32'd2);
        waitHaltA(100, cycles);
        checkOutput("inStoreM12", 32'(dutA.mem_q[12]), 32'h33);

        // PC wrap on the 6/3 instance; start and final write share one IDLE cycle
        writeB(3'd1, 6'h38);
        for (int i = 2; i < 8; i++) writeB(3'(i), 6'h00);
        ifB.mem_we = 1'b1; ifB.mem_addr = 3'd0; ifB.mem_wdata = 6'h2F; ifB.start = 1'b1;
        step(1);
        ifB.mem_we = 1'b0; ifB.start = 1'b0;
        step(3);
        checkOutput("wrapJzPc", 32'(ifB.pc_out), 32'd7);
        step(1);
        checkOutput("wrapPc0", 32'(ifB.pc_out), 32'd0);
        cycles = 4;
        while (!ifB.halted && cycles < 100) begin
            step(1);
            cycles++;
        end
        checkOutput("wrapCycles",  32'(cycles),       32'd11);
        checkOutput("wrapHaltPc",  32'(ifB.pc_out),   32'd2);
        checkOutput("wrapDataOut", 32'(ifB.data_out), 32'h2F);
        checkOutput("wrapApos",    32'(ifB.Apos),     32'd0);
        checkOutput("wrapAeq0",    32'(ifB.Aeq0),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
